// File: rtl/csr_pkg.sv
// Shared types and constants for the UART-to-PSRAM command front-end.
package csr_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        ISSUE   = 3'd2,
        WAIT    = 3'd3,
        RESP    = 3'd4
    } cmd_state_t;

    localparam logic [7:0] OP_READ  = 8'h00;
    localparam logic [7:0] OP_WRITE = 8'h01;

    localparam logic [2:0] RD_LEN = 3'd4;
    localparam logic [2:0] WR_LEN = 3'd6;

    // Total frame length in bytes (opcode included) for the given direction.
    function automatic logic [2:0] frame_len(input logic we);
        return we ? WR_LEN : RD_LEN;
    endfunction

endpackage

// File: rtl/uart_psram_cmd_resp_tx.sv
// Response byte sender: queues up to two bytes (low byte first) and pulses
// the UART transmit request for each, with a guard cycle after every pulse
// because the transmitter raises its busy flag one cycle late.
module resp_tx (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        load_two_i,
    input  logic [15:0] load_data_i,
    input  logic        tx_busy_i,
    output logic        tx_write_o,
    output logic [7:0]  tx_data_o,
    output logic        done_o
);

    logic [1:0]  pend_q, pend_d, pend_s;
    logic [15:0] buf_q, buf_d, buf_s;
    logic        write_q, write_d;
    logic [7:0]  data_q, data_d;

    // Next-state: take a fresh load, then send the next byte when the
    // transmitter is free and we are not in the guard (pulse) cycle.
    always_comb begin
        if (load_i) begin
            pend_s = load_two_i ? 2'd2 : 2'd1;
            buf_s  = load_data_i;
        end else begin
            pend_s = pend_q;
            buf_s  = buf_q;
        end
        pend_d  = pend_s;
        buf_d   = buf_s;
        write_d = 1'b0;
        data_d  = data_q;
        if ((pend_s != 2'd0) && !tx_busy_i && !write_q) begin
            write_d = 1'b1;
            data_d  = buf_s[7:0];
            buf_d   = {8'h00, buf_s[15:8]};
            pend_d  = pend_s - 2'd1;
        end else begin
            write_d = 1'b0;
        end
        done_o = (pend_q == 2'd0) && !write_q && !load_i;
    end

    // Queue and registered transmit outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_q  <= 2'd0;
            buf_q   <= 16'h0000;
            write_q <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            pend_q  <= pend_d;
            buf_q   <= buf_d;
            write_q <= write_d;
            data_q  <= data_d;
        end
    end

    assign tx_write_o = write_q;
    assign tx_data_o  = data_q;

endmodule

// File: rtl/uart_psram_cmd.sv
// UART command front-end: collects a read/write frame, issues one PSRAM
// access, and answers with read data, ACK or NAK over the UART.
module uart_psram_cmd
    import csr_pkg::*;
#(
    parameter int unsigned TIMEOUT_US = 1000,
    parameter logic [7:0]  ACK_BYTE   = 8'h06,
    parameter logic [7:0]  NAK_BYTE   = 8'h15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_1us,
    input  logic        uart_rx_valid,
    input  logic [7:0]  uart_rx_data,
    output logic        uart_rx_read,
    output logic        uart_tx_write,
    output logic [7:0]  uart_tx_data,
    input  logic        uart_tx_busy,
    output logic        psram_stb,
    output logic        psram_we,
    output logic [23:0] psram_addr,
    output logic [15:0] psram_din,
    input  logic        psram_busy,
    input  logic [15:0] psram_rdat,
    output logic        frame_err
);

    localparam int TW = $clog2(TIMEOUT_US + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_US);

    cmd_state_t    state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [23:0]   addr_q, addr_d;
    logic [15:0]   din_q, din_d;
    logic          we_q, we_d;
    logic          stb_q, stb_d;
    logic          first_q, first_d;
    logic          err_q, err_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic          rx_read_s;
    logic          ld_s, ld_two_s, rsp_done_s;
    logic [15:0]   ld_data_s;

    // Frame collection, access sequencing and timeout supervision.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        din_d     = din_q;
        we_d      = we_q;
        stb_d     = 1'b0;
        first_d   = 1'b0;
        err_d     = err_q;
        tmo_d     = tmo_q;
        ld_s      = 1'b0;
        ld_two_s  = 1'b0;
        ld_data_s = 16'h0000;
        rx_read_s = uart_rx_valid && !rst &&
                    ((state_q == IDLE) || (state_q == COLLECT));
        case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (rx_read_s) begin
                    cnt_d = 3'd1;
                    if (uart_rx_data == OP_READ) begin
                        we_d    = 1'b0;
                        state_d = COLLECT;
                    end else if (uart_rx_data == OP_WRITE) begin
                        we_d    = 1'b1;
                        state_d = COLLECT;
                    end else begin
                        ld_s      = 1'b1;
                        ld_data_s = {8'h00, NAK_BYTE};
                        err_d     = 1'b1;
                        state_d   = RESP;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            COLLECT: begin
                // A byte arriving in the expiry cycle takes precedence.
                if (rx_read_s) begin
                    tmo_d = '0;
                    cnt_d = cnt_q + 3'd1;
                    case (cnt_q)
                        3'd1:    addr_d[7:0]   = uart_rx_data;
                        3'd2:    addr_d[15:8]  = uart_rx_data;
                        3'd3:    addr_d[23:16] = uart_rx_data;
                        3'd4:    din_d[7:0]    = uart_rx_data;
                        3'd5:    din_d[15:8]   = uart_rx_data;
                        default: addr_d        = addr_q;
                    endcase
                    if (cnt_q == (frame_len(we_q) - 3'd1)) begin
                        state_d = ISSUE;
                    end else begin
                        state_d = COLLECT;
                    end
                end else if (tmo_q == TMO_MAX) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (tick_1us) begin
                    tmo_d = tmo_q + TW'(1);
                end else begin
                    tmo_d = tmo_q;
                end
            end
            ISSUE: begin
                if (!psram_busy) begin
                    stb_d   = 1'b1;
                    first_d = 1'b1;
                    state_d = WAIT;
                end else begin
                    state_d = ISSUE;
                end
            end
            WAIT: begin
                // Busy is not yet valid in the strobe cycle itself.
                if (first_q) begin
                    state_d = WAIT;
                end else if (!psram_busy) begin
                    ld_s    = 1'b1;
                    state_d = RESP;
                    if (we_q) begin
                        ld_data_s = {8'h00, ACK_BYTE};
                    end else begin
                        ld_two_s  = 1'b1;
                        ld_data_s = psram_rdat;
                    end
                end else begin
                    state_d = WAIT;
                end
            end
            RESP: begin
                if (rsp_done_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered PSRAM/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            addr_q  <= 24'h000000;
            din_q   <= 16'h0000;
            we_q    <= 1'b0;
            stb_q   <= 1'b0;
            first_q <= 1'b0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            we_q    <= we_d;
            stb_q   <= stb_d;
            first_q <= first_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

    resp_tx u_resp_tx (
        .clk_i       (clk),
        .rst_i       (rst),
        .load_i      (ld_s),
        .load_two_i  (ld_two_s),
        .load_data_i (ld_data_s),
        .tx_busy_i   (uart_tx_busy),
        .tx_write_o  (uart_tx_write),
        .tx_data_o   (uart_tx_data),
        .done_o      (rsp_done_s)
    );

    assign uart_rx_read = rx_read_s;
    assign psram_stb    = stb_q;
    assign psram_we     = we_q;
    assign psram_addr   = addr_q;
    assign psram_din    = din_q;
    assign frame_err    = err_q;

endmodule

// File: tb/tb_uart_psram_cmd.sv
// Scoreboard bench for uart_psram_cmd with simple PSRAM and UART-TX models.
module tb_uart_psram_cmd;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick_1us = 1'b0;
    logic        uart_rx_valid = 1'b0;
    logic [7:0]  uart_rx_data = 8'h00;
    logic        uart_rx_read;
    logic        uart_tx_write;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_busy;
    logic        psram_stb;
    logic        psram_we;
    logic [23:0] psram_addr;
    logic [15:0] psram_din;
    logic        psram_busy;
    logic [15:0] psram_rdat;
    logic        frame_err;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        we;
        logic [23:0] addr;
        logic [15:0] din;
    } stb_t;

    stb_t       exp_stb[$];
    logic [7:0] exp_tx[$];

    uart_psram_cmd dut (
        .clk           (clk),
        .rst           (rst),
        .tick_1us      (tick_1us),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_read  (uart_rx_read),
        .uart_tx_write (uart_tx_write),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_busy  (uart_tx_busy),
        .psram_stb     (psram_stb),
        .psram_we      (psram_we),
        .psram_addr    (psram_addr),
        .psram_din     (psram_din),
        .psram_busy    (psram_busy),
        .psram_rdat    (psram_rdat),
        .frame_err     (frame_err)
    );

    always #5 clk = ~clk;

    // PSRAM model: busy for ps_len cycles starting the cycle after a strobe.
    int          ps_cnt = 0;
    int          ps_len = 10;
    logic [15:0] ps_rdat = 16'h0000;
    assign psram_busy = (ps_cnt != 0);
    assign psram_rdat = ps_rdat;
    always @(posedge clk) begin
        if (psram_stb) ps_cnt <= ps_len;
        else if (ps_cnt != 0) ps_cnt <= ps_cnt - 1;
    end

    // UART transmitter model: busy for 4 cycles after each request, or forced.
    int   tx_cnt = 0;
    logic tx_hold = 1'b0;
    assign uart_tx_busy = tx_hold | (tx_cnt != 0);
    always @(posedge clk) begin
        if (uart_tx_write) tx_cnt <= 4;
        else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every strobe and every transmitted byte against the queues.
    logic busy_prev = 1'b0;
    always @(negedge clk) begin
        stb_t e;
        if (psram_stb) begin
            if (exp_stb.size() == 0) begin
                checks++; failures++;
                $display("FAIL stb_unexpected actual=we%0b/%06h expected=none at %0t", psram_we, psram_addr, $time);
            end else begin
                e = exp_stb.pop_front();
                chk("stb_we", {31'd0, psram_we}, {31'd0, e.we});
                chk("stb_addr", {8'd0, psram_addr}, {8'd0, e.addr});
                if (e.we) chk("stb_din", {16'd0, psram_din}, {16'd0, e.din});
            end
        end
        if (uart_tx_write) begin
            chk("tx_while_busy", {31'd0, busy_prev}, 32'd0);
            if (exp_tx.size() == 0) begin
                checks++; failures++;
                $display("FAIL tx_unexpected actual=%02h expected=none at %0t", uart_tx_data, $time);
            end else begin
                chk("tx_byte", {24'd0, uart_tx_data}, {24'd0, exp_tx.pop_front()});
            end
        end
        busy_prev = uart_tx_busy;
    end

    task automatic send_byte(input logic [7:0] b);
        int   n;
        logic got;
        n = 0;
        got = 1'b0;
        uart_rx_valid = 1'b1;
        uart_rx_data  = b;
        while (!got && n < 200) begin
            @(negedge clk);
            got = uart_rx_read;
            n++;
        end
        chk("rx_accept", {31'd0, got}, 32'd1);
        @(posedge clk); #1;
        uart_rx_valid = 1'b0;
    endtask

    // Bytes are packed B0 in bits [7:0], B1 in [15:8], ...
    task automatic send_frame(input int n, input logic [47:0] bytes);
        for (int i = 0; i < n; i++) begin
            send_byte(bytes[8*i +: 8]);
            @(posedge clk); #1;
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_stb.size() != 0 || exp_tx.size() != 0) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        chk(name, {31'd0, (n < 3000)}, 32'd1);
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            @(posedge clk); #1 tick_1us = 1'b1;
            @(posedge clk); #1 tick_1us = 1'b0;
        end
    endtask

    task automatic pulse_reset(input int cyc);
        rst = 1'b1;
        repeat (cyc) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rx_read"}, {31'd0, uart_rx_read}, 32'd0);
        chk({tag, "_tx_write"}, {31'd0, uart_tx_write}, 32'd0);
        chk({tag, "_tx_data"}, {24'd0, uart_tx_data}, 32'd0);
        chk({tag, "_stb"}, {31'd0, psram_stb}, 32'd0);
        chk({tag, "_we"}, {31'd0, psram_we}, 32'd0);
        chk({tag, "_addr"}, {8'd0, psram_addr}, 32'd0);
        chk({tag, "_din"}, {16'd0, psram_din}, 32'd0);
        chk({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
    endtask

    initial begin
        int n;
        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk); #1 rst = 1'b0;

        // Read 00 34 12 00, controller busy 10 cycles, data BEEF.
        ps_len = 10; ps_rdat = 16'hBEEF;
        exp_stb.push_back('{1'b0, 24'h001234, 16'h0000});
        exp_tx.push_back(8'hEF); exp_tx.push_back(8'hBE);
        send_frame(4, 48'h0000_0012_3400);
        drain("drain_read");

        // Write 01 56 34 12 CD AB.
        exp_stb.push_back('{1'b1, 24'h123456, 16'hABCD});
        exp_tx.push_back(8'h06);
        send_frame(6, 48'hABCD_1234_5601);
        drain("drain_write");
        chk("err_after_good", {31'd0, frame_err}, 32'd0);

        // Illegal opcode 07 -> NAK, sticky error.
        exp_tx.push_back(8'h15);
        send_frame(1, 48'h0000_0000_0007);
        drain("drain_nak");
        chk("err_after_nak", {31'd0, frame_err}, 32'd1);

        // A good write afterwards leaves the error flag set.
        exp_stb.push_back('{1'b1, 24'h800000, 16'h1234});
        exp_tx.push_back(8'h06);
        send_frame(6, 48'h1234_8000_0001);
        drain("drain_write2");
        chk("err_sticky", {31'd0, frame_err}, 32'd1);
        pulse_reset(2);
        @(negedge clk);
        chk("err_cleared", {31'd0, frame_err}, 32'd0);
        @(posedge clk); #1;

        // Gap of TIMEOUT_US-1 ticks does not abort the frame.
        ps_len = 4; ps_rdat = 16'h2468;
        exp_stb.push_back('{1'b0, 24'h001234, 16'h0000});
        exp_tx.push_back(8'h68); exp_tx.push_back(8'h24);
        send_frame(2, 48'h0000_0000_3400);
        ticks(999);
        send_frame(2, 48'h0000_0000_0012);
        drain("drain_near_timeout");
        chk("err_near_timeout", {31'd0, frame_err}, 32'd0);

        // Stalled frame: no strobe, no response, error set.
        send_frame(2, 48'h0000_0000_3400);
        ticks(1001);
        repeat (5) @(posedge clk);
        #1;
        chk("err_timeout", {31'd0, frame_err}, 32'd1);

        // Normal read after the timeout.
        ps_rdat = 16'h1357;
        exp_stb.push_back('{1'b0, 24'h345678, 16'h0000});
        exp_tx.push_back(8'h57); exp_tx.push_back(8'h13);
        send_frame(4, 48'h0000_3456_7800);
        drain("drain_recover");

        // Transmitter held busy for 100 cycles during a read response.
        ps_len = 3; ps_rdat = 16'hA55A;
        tx_hold = 1'b1;
        exp_stb.push_back('{1'b0, 24'h000001, 16'h0000});
        exp_tx.push_back(8'h5A); exp_tx.push_back(8'hA5);
        send_frame(4, 48'h0000_0000_0100);
        repeat (100) @(posedge clk);
        #1;
        chk("hold_nothing_sent", exp_tx.size(), 32'd2);
        tx_hold = 1'b0;
        drain("drain_hold");

        // Reset pulse while waiting on the PSRAM: outputs cleared, no response.
        pulse_reset(2);
        ps_len = 20; ps_rdat = 16'h1111;
        exp_stb.push_back('{1'b0, 24'h001000, 16'h0000});
        send_frame(4, 48'h0000_0010_0000);
        n = 0;
        while (exp_stb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("wait_strobe", {31'd0, (n < 100)}, 32'd1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("abort");
        repeat (60) @(posedge clk);
        #1;

        chk("final_stb_queue", exp_stb.size(), 32'd0);
        chk("final_tx_queue", exp_tx.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
